// File: rtl/mc_datapath_if.sv
// Controller/memory <-> multicycle datapath bundle: per-cycle control in, Instr/flags/memory address out.
// Combinational only; no handshake since the controller drives every control on every cycle.
interface mc_datapath_if;
   logic [31:0] Adr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        RegWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [1:0]  ALUControl;

   modport slave (
      input  ReadData, PCWrite, RegWrite, IRWrite, AdrSrc,
             RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
      output Adr, WriteData, Instr, ALUFlags
   );

   modport master (
      output ReadData, PCWrite, RegWrite, IRWrite, AdrSrc,
             RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
      input  Adr, WriteData, Instr, ALUFlags
   );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle ARM datapath: PC, IR, data/A/B/ALUOut pipeline registers, R0-R14, 32-bit ALU.
// Every internal register adds one cycle; no stalls, the controller sequences all accesses.
module mc_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   mc_datapath_if.slave bus
);
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] data_q, data_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;
   logic [31:0] rf_q [15];
   logic [31:0] rf_d [15];

   logic [31:0] ext_imm;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] alu_res;
   logic [3:0]  alu_flags;
   logic [31:0] result;
   logic [3:0]  ra1, ra2, wa3;
   logic [31:0] rd1, rd2;

   always_comb begin
      ext_imm = {24'h0, ir_q[7:0]};
      case (bus.ImmSrc)
         2'b01:   ext_imm = {20'h0, ir_q[11:0]};
         2'b10:   ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
         default: ext_imm = {24'h0, ir_q[7:0]};
      endcase
   end

   always_comb begin
      case (bus.ALUSrcA)
         2'b00:   src_a = a_q;
         2'b01:   src_a = pc_q;
         2'b10:   src_a = aluout_q;
         default: src_a = 32'h0;
      endcase
      case (bus.ALUSrcB)
         2'b00:   src_b = b_q;
         2'b01:   src_b = ext_imm;
         2'b10:   src_b = 32'd4;
         default: src_b = 32'h0;
      endcase
   end

   // SUB reuses the adder as a + ~b + 1, so carry-out is the ARM "no borrow" flag.
   logic        is_sub;
   logic [31:0] b_op;
   logic [32:0] sum;
   logic        c_flag, v_flag;

   always_comb begin
      is_sub  = (bus.ALUControl == 2'b01);
      b_op    = is_sub ? ~src_b : src_b;
      sum     = {1'b0, src_a} + {1'b0, b_op} + {32'h0, is_sub};
      alu_res = sum[31:0];
      c_flag  = 1'b0;
      v_flag  = 1'b0;
      case (bus.ALUControl)
         2'b00, 2'b01: begin
            alu_res = sum[31:0];
            c_flag  = sum[32];
            v_flag  = (src_a[31] == b_op[31]) && (sum[31] != src_a[31]);
         end
         2'b10:   alu_res = src_a & src_b;
         default: alu_res = src_a | src_b;
      endcase
      alu_flags = {alu_res[31], (alu_res == 32'h0), c_flag, v_flag};
   end

   always_comb begin
      case (bus.ResultSrc)
         2'b00:   result = aluout_q;
         2'b01:   result = data_q;
         default: result = alu_res;
      endcase
   end

   // R15 is never stored: reading it returns the live Result bus (PC+8 during decode).
   assign ra1 = bus.RegSrc[0] ? 4'd15 : ir_q[19:16];
   assign ra2 = bus.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
   assign wa3 = ir_q[15:12];
   assign rd1 = (ra1 == 4'd15) ? result : rf_q[ra1];
   assign rd2 = (ra2 == 4'd15) ? result : rf_q[ra2];

   always_comb begin
      pc_d     = bus.PCWrite ? result : pc_q;
      ir_d     = bus.IRWrite ? bus.ReadData : ir_q;
      data_d   = bus.ReadData;
      a_d      = rd1;
      b_d      = rd2;
      aluout_d = alu_res;
      rf_d     = rf_q;
      if (bus.RegWrite && (wa3 != 4'd15)) begin
         rf_d[wa3] = result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= 32'h0;
         data_q   <= 32'h0;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         aluout_q <= 32'h0;
         for (int i = 0; i < 15; i++) begin
            rf_q[i] <= 32'h0;
         end
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         data_q   <= data_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         rf_q     <= rf_d;
      end
   end

   assign bus.Adr       = bus.AdrSrc ? result : pc_q;
   assign bus.WriteData = b_q;
   assign bus.Instr     = ir_q;
   assign bus.ALUFlags  = alu_flags;
endmodule

// File: tb/tb_mc_datapath.sv
// Drives mc_datapath with directed control sequences then random control, checking against an architectural model.
module tb_mc_datapath;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;
   mc_datapath_if bus ();

   mc_datapath #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   assign bus.ReadData = mem[bus.Adr[7:2]];

   typedef struct packed {
      logic       pcw;
      logic       regw;
      logic       irw;
      logic       adrsrc;
      logic [1:0] regsrc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] ressrc;
      logic [1:0] immsrc;
      logic [1:0] aluctl;
   } ctl_t;

   int n_run  = 0;
   int n_fail = 0;

   // architectural state of the model and its next values
   logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_aluout;
   logic [31:0] m_rf [16];
   logic [31:0] n_pc, n_ir, n_data, n_a, n_b, n_aluout;
   logic [31:0] n_rf [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic ctl_t mk(input logic pcw, regw, irw, adrsrc,
                               input logic [1:0] regsrc, srca, srcb, ressrc, immsrc, aluctl);
      ctl_t c;
      c = '{pcw, regw, irw, adrsrc, regsrc, srca, srcb, ressrc, immsrc, aluctl};
      return c;
   endfunction

   function automatic logic [31:0] ext_ref(input logic [31:0] ir, input logic [1:0] sel);
      int x;
      if (sel == 2'b10) begin
         x = $signed(ir[23:0]);
         return x * 4;
      end
      if (sel == 2'b01) return {20'h0, ir[11:0]};
      return {24'h0, ir[7:0]};
   endfunction

   // returns {N,Z,C,V,result}; overflow means the true signed result does not fit in 32 bits
   function automatic logic [35:0] alu_ref(input logic [31:0] a, b, input logic [1:0] op);
      longint sa, sb, sr;
      logic [32:0] w;
      logic [31:0] r;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      case (op)
         2'b00: begin
            w  = {1'b0, a} + {1'b0, b};
            r  = w[31:0];
            c  = w[32];
            sr = sa + sb;
            v  = (sr != longint'($signed(r)));
         end
         2'b01: begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
            v  = (sr != longint'($signed(r)));
         end
         2'b10:   r = a & b;
         default: r = a | b;
      endcase
      return {r[31], (r == 32'h0), c, v, r};
   endfunction

   task automatic drive(input ctl_t c, input logic rst);
      logic [31:0] sa, sb, res, rd1, rd2, adr, rdata;
      logic [35:0] fr;
      logic [3:0]  ra1, ra2, wa;
      reset          = rst;
      bus.PCWrite    = c.pcw;
      bus.RegWrite   = c.regw;
      bus.IRWrite    = c.irw;
      bus.AdrSrc     = c.adrsrc;
      bus.RegSrc     = c.regsrc;
      bus.ALUSrcA    = c.srca;
      bus.ALUSrcB    = c.srcb;
      bus.ResultSrc  = c.ressrc;
      bus.ImmSrc     = c.immsrc;
      bus.ALUControl = c.aluctl;
      case (c.srca)
         2'b00:   sa = m_a;
         2'b01:   sa = m_pc;
         2'b10:   sa = m_aluout;
         default: sa = 32'h0;
      endcase
      case (c.srcb)
         2'b00:   sb = m_b;
         2'b01:   sb = ext_ref(m_ir, c.immsrc);
         2'b10:   sb = 32'd4;
         default: sb = 32'h0;
      endcase
      fr    = alu_ref(sa, sb, c.aluctl);
      res   = (c.ressrc == 2'b00) ? m_aluout : (c.ressrc == 2'b01) ? m_data : fr[31:0];
      adr   = c.adrsrc ? res : m_pc;
      ra1   = c.regsrc[0] ? 4'd15 : m_ir[19:16];
      ra2   = c.regsrc[1] ? m_ir[15:12] : m_ir[3:0];
      rd1   = (ra1 == 4'd15) ? res : m_rf[ra1];
      rd2   = (ra2 == 4'd15) ? res : m_rf[ra2];
      rdata = mem[adr[7:2]];
      #1;
      chk("adr", bus.Adr, adr);
      chk("wdata", bus.WriteData, m_b);
      chk("instr", bus.Instr, m_ir);
      chk("flags", {28'h0, bus.ALUFlags}, {28'h0, fr[35:32]});
      n_rf = m_rf;
      if (rst) begin
         n_pc = RESET_PC; n_ir = 0; n_data = 0; n_a = 0; n_b = 0; n_aluout = 0;
         for (int i = 0; i < 16; i++) n_rf[i] = 32'h0;
      end else begin
         n_pc     = c.pcw ? res : m_pc;
         n_ir     = c.irw ? rdata : m_ir;
         n_data   = rdata;
         n_a      = rd1;
         n_b      = rd2;
         n_aluout = fr[31:0];
         wa       = m_ir[15:12];
         if (c.regw && wa != 4'd15) n_rf[wa] = res;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_pc = n_pc; m_ir = n_ir; m_data = n_data; m_a = n_a; m_b = n_b; m_aluout = n_aluout;
      m_rf = n_rf;
      @(negedge clk);
   endtask

   task automatic step(input ctl_t c);
      drive(c, 1'b0);
      tick();
   endtask

   ctl_t idle, fetch, chain, pc4, rc;

   initial begin
      idle  = '0;
      fetch = mk(1, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
      chain = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
      pc4   = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'hE281_1005;
      mem[1] = 32'hEAFF_FFFE;
      mem[4] = 32'h0000_0001;
      mem[5] = 32'h7FFF_FFFF;
      mem[8] = 32'hDEAD_BEEF;

      reset = 1'b1;
      {bus.PCWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc} = 4'b0;
      {bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl} = 12'b0;
      repeat (2) @(posedge clk);
      m_pc = RESET_PC; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
      @(negedge clk);

      drive(idle, 1'b0);
      chk("rst_adr", bus.Adr, RESET_PC);
      chk("rst_instr", bus.Instr, 32'h0);
      chk("rst_wdata", bus.WriteData, 32'h0);
      tick();
      drive(fetch, 1'b0);
      chk("fetch_adr", bus.Adr, 32'h0);
      tick();
      drive(mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00), 1'b0);
      chk("fetch_ir", bus.Instr, 32'hE281_1005);
      chk("fetch_pc", bus.Adr, 32'd4);
      tick();
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11), 1'b0);
      chk("decode_a", bus.Adr, 32'd8);
      tick();
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), 1'b0);
      chk("add_imm_res", bus.Adr, 32'd5);
      chk("add_imm_flags", {28'h0, bus.ALUFlags}, 32'h0);
      tick();
      step(mk(0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00));
      drive(mk(0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11), 1'b0);
      chk("rf_old_read", bus.Adr, 32'h0);
      tick();
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01), 1'b0);
      chk("sub_eq_res", bus.Adr, 32'h0);
      chk("sub_eq_flags", {28'h0, bus.ALUFlags}, 32'b0110);
      chk("wdata_b", bus.WriteData, 32'd5);
      tick();

      step(pc4);
      repeat (2) step(chain);
      drive(mk(0, 0, 0, 1, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00), 1'b0);
      chk("ld1_adr", bus.Adr, 32'h10);
      tick();
      step(mk(0, 1, 0, 0, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00));
      step(mk(0, 0, 0, 0, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00));
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01), 1'b0);
      chk("sub_neg_res", bus.Adr, 32'hFFFF_FFFF);
      chk("sub_neg_flags", {28'h0, bus.ALUFlags}, 32'b1000);
      tick();

      step(pc4);
      repeat (3) step(chain);
      step(mk(0, 0, 0, 1, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00));
      step(mk(0, 0, 0, 0, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00));
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00), 1'b0);
      chk("add_ovf_res", bus.Adr, 32'h8000_0000);
      chk("add_ovf_flags", {28'h0, bus.ALUFlags}, 32'b1001);
      tick();

      step(pc4);
      repeat (6) step(chain);
      drive(mk(0, 0, 0, 1, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00), 1'b0);
      chk("ldr_adr", bus.Adr, 32'h20);
      tick();
      drive(mk(0, 1, 0, 1, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00), 1'b0);
      chk("ldr_data", bus.Adr, 32'hDEAD_BEEF);
      tick();
      step(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11));
      drive(mk(0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11), 1'b0);
      chk("ldr_r1", bus.Adr, 32'hDEAD_BEEF);
      tick();

      drive(fetch, 1'b0);
      chk("br_fetch_adr", bus.Adr, 32'd4);
      tick();
      step(mk(0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
      drive(mk(1, 1, 0, 1, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00), 1'b0);
      chk("br_target", bus.Adr, 32'd4);
      chk("br_flags", {28'h0, bus.ALUFlags}, 32'b0010);
      tick();
      drive(mk(0, 1, 0, 0, 2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00), 1'b0);
      chk("br_pc", bus.Adr, 32'd4);
      tick();
      drive(idle, 1'b0);
      chk("r15_wr_pc", bus.Adr, 32'd4);
      tick();

      drive(fetch, 1'b1);
      tick();
      drive(idle, 1'b0);
      chk("mid_rst_pc", bus.Adr, RESET_PC);
      chk("mid_rst_ir", bus.Instr, 32'h0);
      tick();

      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int n = 0; n < 2000; n++) begin
         rc = ctl_t'(16'($urandom));
         drive(rc, ($urandom_range(0, 49) == 0));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Multicycle ARM datapath that consumes the per-cycle control bundle from the multicycle controller. It returns Instr and ALUFlags to that controller.
Holds PC, instruction register, data register, register file R0–R14, the A/B operand registers and ALUOut. Drives the shared instruction/data memory address and write data.
One memory access per cycle; the controller sequences fetch/decode/execute/memory/writeback.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
Adr  out  32  memory address: AdrSrc=0 -> PC, 1 -> Result
WriteData  out  32  memory write data = B register
ReadData  in  32  memory read data (combinational from Adr)
Instr  out  32  instruction register contents (controller uses [31:12])
ALUFlags  out  4  {N,Z,C,V} of current ALUResult, combinational
PCWrite  in  1  PC <= Result
RegWrite  in  1  write Result to R[Instr[15:12]]
IRWrite  in  1  IR <= ReadData
AdrSrc  in  1  address select (see Adr)
RegSrc  in  2  [0]: RA1 = 15 if 1 else Instr[19:16]; [1]: RA2 = Instr[15:12] if 1 else Instr[3:0]
ALUSrcA  in  2  00 A reg, 01 PC, 10 ALUOut, 11 32'h0
ALUSrcB  in  2  00 B reg, 01 ExtImm, 10 32'd4, 11 32'h0
ResultSrc  in  2  00 ALUOut, 01 Data reg, 10 ALUResult, 11 ALUResult
ImmSrc  in  2  00 zext Instr[7:0], 01 zext Instr[11:0], 10 sext(Instr[23:0])<<2, 11 treated as 00
ALUControl  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Reset (synchronous, overrides all enables): PC=RESET_PC; IR, Data, A, B, ALUOut = 0; R0–R14 = 0. Outputs follow: Instr=0, Adr=RESET_PC with AdrSrc=0, WriteData=0.
- Every rising edge, not in reset: Data<=ReadData, A<=RD1, B<=RD2, ALUOut<=ALUResult. These are unconditional, so each holds exactly one cycle of latency.
- IR loads only when IRWrite=1; otherwise it holds.
- PC loads Result only when PCWrite=1; otherwise it holds.
- Register file: two combinational reads, one synchronous write.
  - Reads of address 15 return the Result bus combinationally, not stored state. In the decode cycle the controller drives ALUSrcA=01, ALUSrcB=10, ResultSrc=10 after fetch has already advanced PC, so R15 reads PC+8.
  - Write when RegWrite=1 to WA3=Instr[15:12]. A write to 15 is dropped; PC changes only via PCWrite.
  - A read of the register being written in the same cycle returns the old value.
- ALU is 32-bit.
  - ADD: sum = a+b, C = carry-out of bit 31, V = (a[31]==b[31]) && (sum[31]!=a[31]).
  - SUB: a + ~b + 1, C = 1 when there is no borrow (a>=b unsigned), V = (a[31]!=b[31]) && (res[31]!=a[31]).
  - AND/ORR: C=0, V=0.
  - N = res[31]; Z = (res==0).
  - Flags are not stored here; the controller's condition logic latches them.
- Simultaneous PCWrite and RegWrite in one cycle: both take effect from the same Result.
- Simultaneous IRWrite and PCWrite (fetch): IR gets ReadData at the old PC; PC gets Result.
- No internal FSM; all sequencing comes from the controller. The datapath must accept any control combination without X-propagation.
- Unused control encodings (ALUSrcA=11, ALUSrcB=11, ResultSrc=11, ImmSrc=11) are defined as listed in Ports, never X.

Test Plan:
1. Reset then release; memory word0 = 32'hE281_1005. Expect Adr=0 and Instr=0 after reset. Fetch cycle (AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1): Instr=32'hE281_1005 and PC=4 next cycle.
2. Decode cycle after (1), RegSrc=01: ALUResult=8 (PC+4), so RD1 via R15 = 8. Next cycle A=8.
3. Execute ADD R1,R1,#5 (ImmSrc=00, ALUSrcB=01, ALUControl=00) with R1=0, then writeback (ResultSrc=00, RegWrite=1). Expect R1=5 and ALUFlags=0000.
4. SUB with A=5 and B=5 -> ALUResult=0, ALUFlags=0110 (Z=1, C=1). SUB with A=0 and B=1 -> 32'hFFFF_FFFF, ALUFlags=1000. ADD 32'h7FFF_FFFF+1 -> ALUFlags=1001.
5. LDR path: ALUOut=32'h20, AdrSrc=1, ResultSrc=00 presents Adr=32'h20; memory returns 32'hDEAD_BEEF. Next cycle Data=32'hDEAD_BEEF; ResultSrc=01 with RegWrite writes R[Instr[15:12]]. A RegWrite to R15 is ignored and PC is unchanged.
6. Branch: Instr[23:0]=24'hFFFFFE, ImmSrc=10 -> ExtImm=32'hFFFF_FFF8; PC+8=12 plus ExtImm -> 4, PCWrite -> PC=4. Assert reset mid-sequence -> PC=RESET_PC and IR=0 on the next edge.
